// File: rtl/riptide_cfg_loader.sv
// RipTide fabric configuration loader: fetches the config image from SRAM and streams it onto the fabric config bus.
// Optional trailing XOR checksum verification is enabled by defining RIPTIDE_CFG_CHECKSUM_EN.
module riptide_cfg_loader #(
  parameter int ROWS         = 6,
  parameter int COLS         = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int WORDS_PER_PE = 4,
  localparam int NUM_PE      = ROWS * COLS,
  localparam int TOTAL       = NUM_PE * WORDS_PER_PE,
  localparam int PE_W        = (NUM_PE > 1) ? $clog2(NUM_PE) : 1,
  localparam int WORD_W      = (WORDS_PER_PE > 1) ? $clog2(WORDS_PER_PE) : 1,
  localparam int CNT_W       = $clog2(TOTAL + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  cfg_valid,
  input  logic                  cfg_ready,
  output logic [PE_W-1:0]       cfg_pe_idx,
  output logic [WORD_W-1:0]     cfg_word_idx,
  output logic [DATA_WIDTH-1:0] cfg_data,
  output logic                  fabric_cfg_en,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cfg_err_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] word_cnt_r;

`ifdef RIPTIDE_CFG_CHECKSUM_EN
  logic                  chk_phase_r;
  logic [DATA_WIDTH-1:0] xor_acc_r;
  logic [DATA_WIDTH-1:0] chk_word_r;

  function automatic logic [DATA_WIDTH-1:0] checksum_step(input logic [DATA_WIDTH-1:0] acc,
                                                          input logic [DATA_WIDTH-1:0] word);
    return acc ^ word;
  endfunction
`endif

  // Load sequencer; mem_req_addr doubles as the running read address register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= S_IDLE;
      word_cnt_r    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      cfg_valid     <= 1'b0;
      cfg_pe_idx    <= '0;
      cfg_word_idx  <= '0;
      cfg_data      <= '0;
      fabric_cfg_en <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      cfg_err_o     <= 1'b0;
`ifdef RIPTIDE_CFG_CHECKSUM_EN
      chk_phase_r   <= 1'b0;
      xor_acc_r     <= '0;
      chk_word_r    <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start_i) begin
            mem_req_addr  <= base_addr_i;
            word_cnt_r    <= '0;
            cfg_pe_idx    <= '0;
            cfg_word_idx  <= '0;
            cfg_err_o     <= 1'b0;
            mem_req_valid <= 1'b1;
            busy_o        <= 1'b1;
            fabric_cfg_en <= 1'b1;
            state_r       <= S_REQ;
`ifdef RIPTIDE_CFG_CHECKSUM_EN
            chk_phase_r   <= 1'b0;
            xor_acc_r     <= '0;
`endif
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state_r       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
`ifdef RIPTIDE_CFG_CHECKSUM_EN
            if (chk_phase_r) begin
              chk_word_r <= mem_rsp_data;
              state_r    <= S_CHECK;
            end else begin
              cfg_data  <= mem_rsp_data;
              cfg_valid <= 1'b1;
              state_r   <= S_WRITE;
            end
`else
            cfg_data  <= mem_rsp_data;
            cfg_valid <= 1'b1;
            state_r   <= S_WRITE;
`endif
          end
        end
        S_WRITE: begin
          if (cfg_ready) begin
            cfg_valid <= 1'b0;
`ifdef RIPTIDE_CFG_CHECKSUM_EN
            xor_acc_r <= checksum_step(xor_acc_r, cfg_data);
`endif
            if (word_cnt_r == CNT_W'(TOTAL - 1)) begin
`ifdef RIPTIDE_CFG_CHECKSUM_EN
              // Checksum word sits directly after the image.
              chk_phase_r   <= 1'b1;
              mem_req_addr  <= mem_req_addr + ADDR_WIDTH'(4);
              mem_req_valid <= 1'b1;
              state_r       <= S_REQ;
`else
              done_o        <= 1'b1;
              fabric_cfg_en <= 1'b0;
              state_r       <= S_DONE;
`endif
            end else begin
              word_cnt_r    <= word_cnt_r + CNT_W'(1);
              mem_req_addr  <= mem_req_addr + ADDR_WIDTH'(4);
              mem_req_valid <= 1'b1;
              state_r       <= S_REQ;
              if (cfg_word_idx == WORD_W'(WORDS_PER_PE - 1)) begin
                cfg_word_idx <= '0;
                cfg_pe_idx   <= cfg_pe_idx + PE_W'(1);
              end else begin
                cfg_word_idx <= cfg_word_idx + WORD_W'(1);
              end
            end
          end
        end
`ifdef RIPTIDE_CFG_CHECKSUM_EN
        S_CHECK: begin
          cfg_err_o     <= (chk_word_r != xor_acc_r);
          done_o        <= 1'b1;
          fabric_cfg_en <= 1'b0;
          state_r       <= S_DONE;
        end
`endif
        S_DONE: begin
          busy_o  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          mem_req_valid <= 1'b0;
          cfg_valid     <= 1'b0;
          fabric_cfg_en <= 1'b0;
          busy_o        <= 1'b0;
          state_r       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
